lsu_ctrl: RTL and testbench

- Load/store sequencing controller between the core's memory stage and the single-ported data memory.
- Accepts one load/store request at a time and checks alignment.
- Drives word-aligned memory requests with byte enables and lane-shifted store data; waits on memory handshakes.
- Returns loads lane-extracted and sign- or zero-extended.
- Owns the memory port exclusively; at most one transaction outstanding.

---
 rtl/lsu_ctrl_if.sv | 40 ++++
 rtl/lsu_ctrl.sv | 133 +++++++++++++
 tb/tb_lsu_ctrl.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/lsu_ctrl_if.sv
// Core request, data-memory port and response bundle for the load/store unit.
// slave = the controller, master = the core/memory environment around it.
interface lsu_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_width;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport slave (
        input  req_valid, req_we, req_width, req_unsigned,
        input  req_addr, req_wdata,
        output req_ready,
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata,
        output rsp_valid, rsp_rdata, rsp_err
    );

    modport master (
        output req_valid, req_we, req_width, req_unsigned,
        output req_addr, req_wdata,
        input  req_ready,
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata,
        input  rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/lsu_ctrl.sv
// Load/store sequencer: alignment check, lane steering, one access in flight,
// load extraction/extension and a per-phase memory timeout.
module lsu_ctrl #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input logic      clk,
    input logic      rst_n,
    lsu_ctrl_if.slave bus
);
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] TLIM = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    state_t      state, state_n;
    logic        we_q, uns_q, err_q;
    logic [1:0]  width_q, lane_q;
    logic [31:0] addr_q, wd_q, rdata_q;
    logic [3:0]  be_q;
    logic [CW-1:0] cnt;

    logic        accept, misalign, tmo, err_n;
    logic [3:0]  be_c;
    logic [31:0] wd_c, rsh, ext_c;

    assign accept = (state == IDLE) && bus.req_valid;
    assign tmo    = (TIMEOUT_CYCLES != 0) && (cnt == TLIM);

    always_comb begin
        misalign = 1'b1;
        be_c     = 4'b1111;
        wd_c     = bus.req_wdata;
        unique case (bus.req_width)
            2'b00: begin
                misalign = 1'b0;
                be_c     = 4'b0001 << bus.req_addr[1:0];
                wd_c     = 32'(bus.req_wdata[7:0]) << {bus.req_addr[1:0], 3'b000};
            end
            2'b01: begin
                misalign = bus.req_addr[0];
                be_c     = 4'b0011 << {bus.req_addr[1], 1'b0};
                wd_c     = 32'(bus.req_wdata[15:0]) << {bus.req_addr[1], 4'b0000};
            end
            2'b10: misalign = |bus.req_addr[1:0];
            default: misalign = 1'b1;
        endcase
    end

    always_comb begin
        rsh   = bus.mem_rdata >> {lane_q, 3'b000};
        ext_c = bus.mem_rdata;
        unique case (width_q)
            2'b00: ext_c = uns_q ? {24'b0, rsh[7:0]} : {{24{rsh[7]}}, rsh[7:0]};
            2'b01: ext_c = uns_q ? {16'b0, rsh[15:0]} : {{16{rsh[15]}}, rsh[15:0]};
            default: ext_c = bus.mem_rdata;
        endcase
    end

    always_comb begin
        state_n = state;
        err_n   = 1'b0;
        unique case (state)
            IDLE: if (bus.req_valid) begin
                state_n = misalign ? RESP : REQ;
                err_n   = misalign;
            end
            REQ: if (bus.mem_gnt) begin
                state_n = we_q ? RESP : WAIT;
            end else if (tmo) begin
                state_n = RESP;
                err_n   = 1'b1;
            end
            WAIT: if (bus.mem_rvalid) begin
                state_n = RESP;
            end else if (tmo) begin
                state_n = RESP;
                err_n   = 1'b1;
            end
            RESP: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            width_q <= 2'b00;
            lane_q  <= 2'b00;
            addr_q  <= '0;
            be_q    <= '0;
            wd_q    <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            cnt     <= '0;
        end else begin
            if (accept) begin
                we_q    <= bus.req_we;
                uns_q   <= bus.req_unsigned;
                width_q <= bus.req_width;
                lane_q  <= bus.req_addr[1:0];
                addr_q  <= {bus.req_addr[31:2], 2'b00};
                be_q    <= be_c;
                wd_q    <= wd_c;
            end
            // WAIT leaving without error can only mean rvalid arrived
            if (state != RESP && state_n == RESP) begin
                err_q   <= err_n;
                rdata_q <= (state == WAIT && !err_n) ? ext_c : '0;
            end
            if ((state_n == REQ && state != REQ) ||
                (state_n == WAIT && state != WAIT))
                cnt <= '0;
            else if (state == REQ || state == WAIT)
                cnt <= cnt + 1'b1;
        end
    end

    assign bus.req_ready = (state == IDLE);
    assign bus.mem_req   = (state == REQ);
    assign bus.mem_we    = (state == REQ) && we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_be    = be_q;
    assign bus.mem_wdata = wd_q;
    assign bus.rsp_valid = (state == RESP);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = (state == RESP) && err_q;
endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: lanes, extension, errors, stalls, timeout,
// asynchronous reset mid-load.
module tb_lsu_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    lsu_ctrl_if bus ();

    lsu_ctrl #(.TIMEOUT_CYCLES(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // drive a request at this negedge; returns at the negedge after accept
    task automatic issue(input logic we, input logic [1:0] w, input logic u,
                         input logic [31:0] a, input logic [31:0] d);
        bus.req_valid    = 1'b1;
        bus.req_we       = we;
        bus.req_width    = w;
        bus.req_unsigned = u;
        bus.req_addr     = a;
        bus.req_wdata    = d;
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    task automatic load_byte(input logic u, input logic [31:0] exp);
        issue(1'b0, 2'b00, u, 32'h202, 32'h0);
        check("lb_be", 32'(bus.mem_be), 32'h4);
        check("lb_we", 32'(bus.mem_we), 32'h0);
        check("lb_addr", bus.mem_addr, 32'h200);
        bus.mem_gnt = 1'b1;
        @(negedge clk);
        bus.mem_gnt = 1'b0;
        check("lb_wait_req", 32'(bus.mem_req), 32'h0);
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h12F45678;
        @(negedge clk);
        bus.mem_rvalid = 1'b0;
        check("lb_valid", 32'(bus.rsp_valid), 32'h1);
        check("lb_rdata", bus.rsp_rdata, exp);
        check("lb_err", 32'(bus.rsp_err), 32'h0);
        @(negedge clk);
    endtask

    task automatic bad_req(input logic [1:0] w, input logic [31:0] a);
        issue(1'b0, w, 1'b0, a, 32'h0);
        check("err_mem_req", 32'(bus.mem_req), 32'h0);
        check("err_valid", 32'(bus.rsp_valid), 32'h1);
        check("err_err", 32'(bus.rsp_err), 32'h1);
        check("err_rdata", bus.rsp_rdata, 32'h0);
        @(negedge clk);
        check("err_idle", 32'(bus.req_ready), 32'h1);
    endtask

    initial begin
        bus.req_valid    = 1'b0;
        bus.req_we       = 1'b0;
        bus.req_width    = 2'b00;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = '0;
        bus.req_wdata    = '0;
        bus.mem_gnt      = 1'b0;
        bus.mem_rvalid   = 1'b0;
        bus.mem_rdata    = '0;

        #1;
        check("rst_ready", 32'(bus.req_ready), 32'h1);
        check("rst_mem_req", 32'(bus.mem_req), 32'h0);
        check("rst_valid", 32'(bus.rsp_valid), 32'h0);
        check("rst_rdata", bus.rsp_rdata, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // store byte to lane 3, granted on first REQ cycle
        bus.mem_gnt = 1'b1;
        issue(1'b1, 2'b00, 1'b0, 32'h103, 32'h000000A5);
        check("sb_req", 32'(bus.mem_req), 32'h1);
        check("sb_we", 32'(bus.mem_we), 32'h1);
        check("sb_addr", bus.mem_addr, 32'h100);
        check("sb_be", 32'(bus.mem_be), 32'h8);
        check("sb_wdata", bus.mem_wdata, 32'hA5000000);
        check("sb_nvalid", 32'(bus.rsp_valid), 32'h0);
        @(negedge clk);
        bus.mem_gnt = 1'b0;
        check("sb_valid", 32'(bus.rsp_valid), 32'h1);
        check("sb_err", 32'(bus.rsp_err), 32'h0);
        check("sb_rdata", bus.rsp_rdata, 32'h0);
        @(negedge clk);
        check("sb_pulse", 32'(bus.rsp_valid), 32'h0);

        // store half to upper lane
        bus.mem_gnt = 1'b1;
        issue(1'b1, 2'b01, 1'b0, 32'h12, 32'hCAFE1234);
        check("sh_be", 32'(bus.mem_be), 32'hC);
        check("sh_wdata", bus.mem_wdata, 32'h12340000);
        @(negedge clk);
        bus.mem_gnt = 1'b0;
        @(negedge clk);

        load_byte(1'b0, 32'hFFFFFFF4);
        load_byte(1'b1, 32'h000000F4);

        bad_req(2'b01, 32'h301);
        bad_req(2'b11, 32'h0);

        // LW with gnt after 3 stall cycles, rvalid 2 cycles after gnt
        issue(1'b0, 2'b10, 1'b0, 32'h40, 32'h0);
        for (int i = 0; i < 4; i++) begin
            check("lw_req_hold", 32'(bus.mem_req), 32'h1);
            check("lw_addr_hold", bus.mem_addr, 32'h40);
            check("lw_be", 32'(bus.mem_be), 32'hF);
            if (i == 3) bus.mem_gnt = 1'b1;
            @(negedge clk);
        end
        bus.mem_gnt = 1'b0;
        check("lw_wait_req", 32'(bus.mem_req), 32'h0);
        @(negedge clk);
        check("lw_wait_nvalid", 32'(bus.rsp_valid), 32'h0);
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'hDEADBEEF;
        @(negedge clk);
        check("lw_valid", 32'(bus.rsp_valid), 32'h1);
        check("lw_rdata", bus.rsp_rdata, 32'hDEADBEEF);
        check("lw_err", 32'(bus.rsp_err), 32'h0);
        bus.mem_rdata = 32'h11111111;
        @(negedge clk);
        @(negedge clk);
        bus.mem_rvalid = 1'b0;
        check("stray_nvalid", 32'(bus.rsp_valid), 32'h0);
        check("stray_ready", 32'(bus.req_ready), 32'h1);
        check("stray_hold", bus.rsp_rdata, 32'hDEADBEEF);

        // timeout with grant withheld
        issue(1'b1, 2'b10, 1'b0, 32'h80, 32'h55AA55AA);
        for (int i = 0; i < 4; i++) begin
            check("to_req", 32'(bus.mem_req), 32'h1);
            @(negedge clk);
        end
        check("to_req_drop", 32'(bus.mem_req), 32'h0);
        check("to_valid", 32'(bus.rsp_valid), 32'h1);
        check("to_err", 32'(bus.rsp_err), 32'h1);
        check("to_rdata", bus.rsp_rdata, 32'h0);
        @(negedge clk);
        bus.mem_gnt = 1'b1;
        issue(1'b1, 2'b10, 1'b0, 32'h84, 32'h0BADF00D);
        check("to_next_wdata", bus.mem_wdata, 32'h0BADF00D);
        @(negedge clk);
        bus.mem_gnt = 1'b0;
        check("to_next_valid", 32'(bus.rsp_valid), 32'h1);
        check("to_next_err", 32'(bus.rsp_err), 32'h0);
        @(negedge clk);

        // asynchronous reset while a load waits for data
        bus.mem_gnt = 1'b1;
        issue(1'b0, 2'b10, 1'b0, 32'h44, 32'h0);
        @(negedge clk);
        bus.mem_gnt = 1'b0;
        check("rw_addr_pre", bus.mem_addr, 32'h44);
        #2 rst_n = 1'b0;
        #1;
        check("rw_mem_req", 32'(bus.mem_req), 32'h0);
        check("rw_addr", bus.mem_addr, 32'h0);
        check("rw_be", 32'(bus.mem_be), 32'h0);
        check("rw_wdata", bus.mem_wdata, 32'h0);
        check("rw_valid", 32'(bus.rsp_valid), 32'h0);
        check("rw_ready", 32'(bus.req_ready), 32'h1);
        @(negedge clk);
        rst_n = 1'b1;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h77777777;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rw_late_nvalid", 32'(bus.rsp_valid), 32'h0);
        end
        bus.mem_rvalid = 1'b0;
        check("rw_late_rdata", bus.rsp_rdata, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
